// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, FSM encoding and field constants for the interrupt controller
package irq_ctrl_pkg;
  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_EDGE = 3'd2;
  localparam logic [2:0] REG_CLAIM = 3'd3;
  localparam logic [2:0] REG_DONE = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam int CLAIM_VALID_BIT = 31;
  localparam int ID_W = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder over eligible sources
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] eligible,
  output logic             any,
  output logic [ID_W-1:0]  sel
);
  // scan from the top down so the lowest set index is written last
  always_comb begin
    any = |eligible;
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) sel = eligible[i] ? ID_W'(i) : sel;
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: masked, prioritised interrupt controller with claim/complete handshake
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [29:0]      addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] src_irq,
  output logic [N_SRC-1:0] hwint,
  output logic             irq
);
  logic [N_SRC-1:0] pend, mask, edge_en, src_q, clr, eligible, rise;
  logic [ID_W-1:0] id, sel;
  logic any, claim, done;
  logic [2:0] idx;
  logic unused;
  state_t state, state_n;
  assign idx = addr[2:0];
  assign unused = ^{addr[29:3], din[31:N_SRC]};
  assign eligible = pend & mask;
  assign rise = src_irq & ~src_q;
  assign claim = state == ASSERT && re && idx == REG_CLAIM && any;
  assign done = state == SERVICE && we && idx == REG_DONE && din[ID_W-1:0] == id;
  assign clr = (we && idx == REG_PEND ? din[N_SRC-1:0] : '0) |
               (claim ? {{(N_SRC-1){1'b0}}, 1'b1} << sel : '0);
  irq_prio_enc #(.N_SRC(N_SRC)) u_enc (.eligible(eligible), .any(any), .sel(sel));
  // state register; irq is registered from the next state so it is high exactly in ASSERT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irq <= 1'b0;
    end else begin
      state <= state_n;
      irq <= state_n == ASSERT;
    end
  end
  // next-state: a claim wins over an eligible drop; DONE must name the claimed id
  always_comb begin
    state_n = state == IDLE    ? (any ? ASSERT : IDLE) :
              state == ASSERT  ? (claim ? SERVICE : any ? ASSERT : IDLE) :
              state == SERVICE ? (done ? IDLE : SERVICE) : IDLE;
  end
  // pending capture (a new edge beats a same-cycle clear), config regs and claimed id
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
      edge_en <= '0;
      src_q <= '0;
      hwint <= '0;
      id <= '0;
    end else begin
      src_q <= src_irq;
      pend <= (edge_en & ((pend & ~clr) | rise)) | (~edge_en & src_irq);
      hwint <= eligible;
      if (we && idx == REG_MASK) mask <= din[N_SRC-1:0];
      if (we && idx == REG_EDGE) edge_en <= din[N_SRC-1:0];
      if (claim) id <= sel;
    end
  end
  // combinational read mux
  always_comb begin
    dout = '0;
    case (idx)
      REG_PEND: dout[N_SRC-1:0] = pend;
      REG_MASK: dout[N_SRC-1:0] = mask;
      REG_EDGE: dout[N_SRC-1:0] = edge_en;
      REG_CLAIM: begin
        dout[CLAIM_VALID_BIT] = state == ASSERT && any;
        dout[ID_W-1:0] = state == ASSERT ? sel : state == SERVICE ? id : '0;
      end
      REG_STATUS: dout[2:0] = {state == SERVICE, state};
      default: dout = '0;
    endcase
  end
endmodule
